// File: rtl/display_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Segment encoding is active-low {g,f,e,d,c,b,a}.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0011000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

endpackage

// File: rtl/display_controller_if.sv
// Prediction handshake between the inference core and the display controller.
// The core is the master; the display controller is the slave.
interface display_controller_if;

    logic       pred_valid;
    logic [3:0] pred_num;
    logic       pred_ready;

    modport master (
        output pred_valid,
        output pred_num,
        input  pred_ready
    );

    modport slave (
        input  pred_valid,
        input  pred_num,
        output pred_ready
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Invalid slots and values above 9 show blank.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       valid,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (valid) begin
            case (value)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_controller.sv
// Prediction history on seven-segment displays with a minimum hold per result.
// Optional newest-digit blink during hold: define DISP_BLINK_EN.
module display_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int HOLD_CYCLES  = 4,
    parameter int BLINK_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            clear,
    display_controller_if.slave             pred,
    output logic [$clog2(NUM_DIGITS+1)-1:0] hist_count,
    output seg_t                            digit [NUM_DIGITS]
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (NUM_DIGITS < 1 || HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad
        $error("display_controller: parameters must be >= 1");
    end

    state_t          state;
    state_t          state_nx;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_nx;
    logic            accept;
    logic [3:0]      slot_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] slot_vld;
    logic [NUM_DIGITS-1:0] show_vld;
    logic            show0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    // Clear overrides the FSM and also masks ready for that cycle.
    always_comb begin
        state_nx        = state;
        hold_nx         = hold_cnt;
        accept          = 1'b0;
        pred.pred_ready = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            hold_nx  = '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    pred.pred_ready = 1'b1;
                    if (pred.pred_valid) begin
                        accept   = 1'b1;
                        hold_nx  = HW'(HOLD_CYCLES - 1);
                        state_nx = HOLD;
                    end
                end
                (state == HOLD): begin
                    if (hold_cnt == '0) begin
                        state_nx = IDLE;
                    end else begin
                        hold_nx = hold_cnt - 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            slot_vld   <= '0;
            hist_count <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_val[i] <= '0;
            end
        end else if (clear) begin
            slot_vld   <= '0;
            hist_count <= '0;
        end else if (accept) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                slot_val[i] <= slot_val[i-1];
                slot_vld[i] <= slot_vld[i-1];
            end
            slot_val[0] <= pred.pred_num;
            slot_vld[0] <= 1'b1;
            if (hist_count != CW'(NUM_DIGITS)) begin
                hist_count <= hist_count + 1'b1;
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Phase restarts "shown" on every accept and idles shown.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (clear || accept || state != HOLD) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign show0 = !(state == HOLD && blink_off);
`else
    assign show0 = 1'b1;
`endif

    always_comb begin
        show_vld    = slot_vld;
        show_vld[0] = slot_vld[0] & show0;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .value (slot_val[g]),
            .valid (show_vld[g]),
            .seg   (digit[g])
        );
    end

endmodule
